// File: rtl/hazard_detection_unit.sv
// Purpose : resolves hazards that forwarding cannot cover (load-use, ID-branch on load),
//           flushes IF/ID on redirect, and freezes the whole pipe during dmem wait states.
// Latency : combinational outputs from the current inputs and the RUN/STALL state; state updates on clk.
// Backpressure: a freeze (EX_MEM_mem_req && !dmem_ready) overrides everything and holds state.
// Ports   : ID opcode/rs1/rs2, EX and MEM load flags and rd, MEM request/ready, redirect in;
//           pipeline-register write enables, flushes and hazard_stall out.
// Option  : define HAZARD_PERF_CNT_EN to add stall_cycles, freeze_cycles and flush_count outputs.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

module hazard_detection_unit #(
  parameter int REG_ADDR_WIDTH = `REG_ADDR_WIDTH,
  parameter int PERF_CNT_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [6:0]                IF_ID_inst_opcode,
  input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2,
  input  logic                      ID_EX_mem_rd_en,
  input  logic [REG_ADDR_WIDTH-1:0] ID_EX_rd,
  input  logic                      EX_MEM_mem_rd_en,
  input  logic [REG_ADDR_WIDTH-1:0] EX_MEM_rd,
  input  logic                      EX_MEM_mem_req,
  input  logic                      dmem_ready,
  input  logic                      redirect,
  output logic                      pc_wr_en,
  output logic                      IF_ID_wr_en,
  output logic                      IF_ID_flush,
  output logic                      ID_EX_wr_en,
  output logic                      ID_EX_flush,
  output logic                      EX_MEM_wr_en,
  output logic                      MEM_WB_flush,
`ifdef HAZARD_PERF_CNT_EN
  output logic [PERF_CNT_WIDTH-1:0] stall_cycles,
  output logic [PERF_CNT_WIDTH-1:0] freeze_cycles,
  output logic [PERF_CNT_WIDTH-1:0] flush_count,
`endif
  output logic                      hazard_stall
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALU    = 7'b0110011;

  logic [0:0] state_q, state_d;
  logic [1:0] cnt_q, cnt_d;

  logic       uses_rs1, uses_rs2, id_resolved;
  logic       match_ex, match_mem;
  logic [1:0] need_n;
  logic       freeze, stall, redirect_flush;

  // Source-operand usage from the ID opcode.
  always_comb begin
    uses_rs1    = !((IF_ID_inst_opcode == OP_LUI) || (IF_ID_inst_opcode == OP_AUIPC) ||
                    (IF_ID_inst_opcode == OP_JAL));
    uses_rs2    = (IF_ID_inst_opcode == OP_ALU) || (IF_ID_inst_opcode == OP_STORE) ||
                  (IF_ID_inst_opcode == OP_BRANCH);
    id_resolved = (IF_ID_inst_opcode == OP_BRANCH) || (IF_ID_inst_opcode == OP_JALR);
  end

  // Only loads matter: ALU results reach every consumer through forwarding.
  always_comb begin
    match_ex  = ID_EX_mem_rd_en && (ID_EX_rd != '0) &&
                ((uses_rs1 && (IF_ID_rs1 == ID_EX_rd)) || (uses_rs2 && (IF_ID_rs2 == ID_EX_rd)));
    match_mem = EX_MEM_mem_rd_en && (EX_MEM_rd != '0) &&
                ((uses_rs1 && (IF_ID_rs1 == EX_MEM_rd)) || (uses_rs2 && (IF_ID_rs2 == EX_MEM_rd)));
  end

  // Branches/JALR compare in ID, so they need the load data one stage earlier than EX users.
  always_comb begin
    need_n = 2'd0;
    if (id_resolved && match_ex)       need_n = 2'd2;
    else if (id_resolved && match_mem) need_n = 2'd1;
    else if (!id_resolved && match_ex) need_n = 2'd1;
  end

  always_comb begin
    freeze         = EX_MEM_mem_req && !dmem_ready;
    stall          = (state_q == ST_STALL) || (need_n != 2'd0);
    redirect_flush = redirect && !stall && !freeze;
  end

  // A freeze holds state and cnt; STALL runs its remaining cycles without re-evaluating.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!freeze) begin
      if (state_q == ST_STALL) begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_d == 2'd0) state_d = ST_RUN;
      end else if (need_n == 2'd2) begin
        state_d = ST_STALL;
        cnt_d   = 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    pc_wr_en     = 1'b1;
    IF_ID_wr_en  = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_wr_en  = 1'b1;
    ID_EX_flush  = 1'b0;
    EX_MEM_wr_en = 1'b1;
    MEM_WB_flush = 1'b0;
    hazard_stall = stall || freeze;
    if (!rst_n) begin
      pc_wr_en     = 1'b0;
      IF_ID_wr_en  = 1'b0;
      IF_ID_flush  = 1'b1;
      ID_EX_wr_en  = 1'b0;
      ID_EX_flush  = 1'b1;
      EX_MEM_wr_en = 1'b0;
      MEM_WB_flush = 1'b1;
      hazard_stall = 1'b0;
    end else if (freeze) begin
      pc_wr_en     = 1'b0;
      IF_ID_wr_en  = 1'b0;
      ID_EX_wr_en  = 1'b0;
      EX_MEM_wr_en = 1'b0;
      MEM_WB_flush = 1'b1;
    end else if (stall) begin
      pc_wr_en     = 1'b0;
      IF_ID_wr_en  = 1'b0;
      ID_EX_flush  = 1'b1;
    end else if (redirect_flush) begin
      IF_ID_flush  = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_CNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;
  logic [PERF_CNT_WIDTH-1:0] freeze_cycles_q, freeze_cycles_d;
  logic [PERF_CNT_WIDTH-1:0] flush_count_q, flush_count_d;

  // Saturating counters; a stall cycle hidden behind a freeze is counted as a freeze only.
  always_comb begin
    stall_cycles_d  = stall_cycles_q;
    freeze_cycles_d = freeze_cycles_q;
    flush_count_d   = flush_count_q;
    if (freeze && (freeze_cycles_q != '1))          freeze_cycles_d = freeze_cycles_q + 1'b1;
    if (!freeze && stall && (stall_cycles_q != '1)) stall_cycles_d  = stall_cycles_q + 1'b1;
    if (redirect_flush && (flush_count_q != '1))    flush_count_d   = flush_count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q  <= '0;
      freeze_cycles_q <= '0;
      flush_count_q   <= '0;
    end else begin
      stall_cycles_q  <= stall_cycles_d;
      freeze_cycles_q <= freeze_cycles_d;
      flush_count_q   <= flush_count_d;
    end
  end

  assign stall_cycles  = stall_cycles_q;
  assign freeze_cycles = freeze_cycles_q;
  assign flush_count   = flush_count_q;
`endif

endmodule

// File: doc/hazard_detection_unit.md
Name: hazard_detection_unit

Overview:
Companion to the pipeline forwarding logic in the 5-stage RISC-V core. It covers the hazards that forwarding cannot resolve, and drives PC and pipeline-register enables, flushes and bubbles.
- Load-use stalls.
- Multi-cycle stalls for ID-resolved branches/JALR waiting on loads.
- Control-redirect flushes.
- Whole-pipeline freeze during data-memory wait states.

Parameters:
REG_ADDR_WIDTH, `REG_ADDR_WIDTH (5), register address width
PERF_CNT_WIDTH, 32, width of optional performance counters

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
IF_ID_inst_opcode  input  7  opcode of instruction in ID
IF_ID_rs1  input  REG_ADDR_WIDTH  ID rs1
IF_ID_rs2  input  REG_ADDR_WIDTH  ID rs2
ID_EX_mem_rd_en  input  1  instruction in EX is a load
ID_EX_rd  input  REG_ADDR_WIDTH  EX destination
EX_MEM_mem_rd_en  input  1  instruction in MEM is a load
EX_MEM_rd  input  REG_ADDR_WIDTH  MEM destination
EX_MEM_mem_req  input  1  MEM-stage load/store active
dmem_ready  input  1  data memory completes access this cycle
redirect  input  1  ID resolved taken branch / JAL / JALR
pc_wr_en  output  1  PC update enable
IF_ID_wr_en  output  1  IF/ID register enable
IF_ID_flush  output  1  IF/ID register cleared to NOP
ID_EX_wr_en  output  1  ID/EX register enable
ID_EX_flush  output  1  insert bubble into ID/EX
EX_MEM_wr_en  output  1  EX/MEM register enable
MEM_WB_flush  output  1  insert bubble into MEM/WB
hazard_stall  output  1  stall or freeze active this cycle

Behaviour:
- Source usage decoded from IF_ID_inst_opcode:
  - rs1 is used by all opcodes except 0110111 (LUI), 0010111 (AUIPC) and 1101111 (JAL).
  - rs2 is used by 0110011, 0100011 and 1100011 only.
  - ID-resolved consumers are 1100011 (branch) and 1100111 (JALR).
- A match requires: source used, producer rd != 0, rd equals the source.
- Required stall count N, computed in RUN only; the first rule that applies wins:
  - ID-resolved consumer matching ID_EX_rd with ID_EX_mem_rd_en -> N=2.
  - ID-resolved consumer matching EX_MEM_rd with EX_MEM_mem_rd_en -> N=1.
  - Non-ID-resolved consumer matching ID_EX_rd with ID_EX_mem_rd_en -> N=1.
  - Otherwise N=0. ALU producers are covered by forwarding.
- FSM states: RUN and STALL, with a 2-bit remaining-cycle counter cnt.
  - RUN with N>0: stall this cycle. If N=2, go to STALL with cnt=1; if N=1, stay in RUN.
  - STALL: stall unconditionally with no re-evaluation. Decrement cnt and return to RUN when cnt reaches 0.
- Stall cycle outputs: pc_wr_en=0, IF_ID_wr_en=0, ID_EX_flush=1; all other enables 1.
- Freeze (EX_MEM_mem_req && !dmem_ready) has highest priority and is evaluated combinationally every cycle:
  - Outputs: pc_wr_en=0, IF_ID_wr_en=0, ID_EX_wr_en=0, EX_MEM_wr_en=0, MEM_WB_flush=1, ID_EX_flush=0, IF_ID_flush=0.
  - State and cnt hold.
  - The cycle with dmem_ready=1 is a normal cycle.
- redirect gives IF_ID_flush=1 only when there is no stall and no freeze that cycle; otherwise it is ignored, because the operands are not yet valid.
- hazard_stall = stall OR freeze.
- Default (no event): all *_wr_en=1, all flushes=0.
- Reset: asynchronous to RUN with cnt=0. While rst_n=0, outputs are:
  - pc_wr_en=0, IF_ID_wr_en=0, ID_EX_wr_en=0, EX_MEM_wr_en=0;
  - IF_ID_flush=1, ID_EX_flush=1, MEM_WB_flush=1;
  - hazard_stall=0.
- Reset mid-STALL abandons the remaining cycles.

Optional Feature:
HAZARD_PERF_CNT_EN: when defined, adds outputs stall_cycles, freeze_cycles and flush_count (each PERF_CNT_WIDTH bits).
- Each is an up-counter that saturates at all-ones and resets to 0.
- Counts, respectively: stall cycles, freeze cycles, and IF_ID_flush cycles caused by redirect.
- When undefined, these ports and registers do not exist; behaviour is otherwise identical.

Test Plan:
- Load x5 in EX, ID is ADD rs1=x5 -> one cycle of pc_wr_en=0, ID_EX_flush=1, then normal flow; 0 stalls if the ADD is replaced by LUI x5.
- Load x0 in EX, ID is ADD rs1=x0 -> no stall.
- Load x7 in EX, ID is BEQ rs2=x7 -> exactly 2 stall cycles (RUN->STALL->RUN), then redirect=1 -> IF_ID_flush=1 for 1 cycle.
- Load x7 in MEM, ID is JALR rs1=x7 -> 1 stall cycle.
- EX_MEM_mem_req=1, dmem_ready=0 for 3 cycles during STALL with cnt=1 -> freeze outputs for 3 cycles, cnt held, 1 stall cycle remaining afterwards.
- rst_n asserted mid-STALL -> immediately the reset output values; after release, state RUN and defaults with no residual stall.
